// File: rtl/prog_timer.sv
// prog_timer: programmable periodic/one-shot tick timer; optional tick counter via PROG_TIMER_TICK_CNT_EN
module prog_timer #(
  parameter int C_CLK_FREQ = 100_000_000,
  parameter int C_TIM_FREQ = 100,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
`ifdef PROG_TIMER_TICK_CNT_EN
  ,output logic [15:0]     tick_cnt_o
`endif
);
  localparam int C_DEF_PERIOD = C_CLK_FREQ / C_TIM_FREQ;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (C_DEF_PERIOD < 1 || (longint'(C_DEF_PERIOD) >> CNT_W) != 0) begin : g_period_chk
    $error("prog_timer: C_CLK_FREQ/C_TIM_FREQ must be in [1, 2**CNT_W)");
  end

  logic [0:0]       r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             w_tc;
  logic             w_load_ok;
  logic             w_start_ok;

  assign w_tc       = (r_state == S_RUN) && en_i && (r_cnt == r_period - CNT_W'(1));
  assign w_load_ok  = load_i && (period_i != '0);
  assign w_start_ok = (r_state == S_IDLE) && start_i && !stop_i;
  assign tick_o     = w_tc;
  assign busy_o     = (r_state == S_RUN);
  assign count_o    = r_cnt;

  // period register: reloads on any nonzero load, independent of state and stop
  always_ff @(posedge clk_i) begin
    if (rst_i) r_period <= CNT_W'(C_DEF_PERIOD);
    else if (w_load_ok) r_period <= period_i;
  end

  // FSM and counter: stop beats start/load-restart, load-restart beats wrap/increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else if (stop_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (start_i) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_mode  <= mode_i;
      end
    end else if (w_load_ok) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_state <= r_mode ? S_IDLE : S_RUN;
    end else if (en_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef PROG_TIMER_TICK_CNT_EN
  logic [15:0] r_tick_cnt;
  assign tick_cnt_o = r_tick_cnt;

  // saturating tick counter, restarted by each accepted start
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_ok) r_tick_cnt <= '0;
    else if (w_tc && r_tick_cnt != 16'hFFFF) r_tick_cnt <= r_tick_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed self-checking bench for prog_timer (default period 10)
module tb_prog_timer;
  logic       clk = 0, rst = 1, start = 0, stop = 0, en = 0, mode = 0, load = 0;
  logic [7:0] period = 0;
  logic       tick, busy;
  logic [7:0] count;
  int n_vec = 0, n_err = 0, n_tick = 0;
`ifdef PROG_TIMER_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  prog_timer #(.C_CLK_FREQ(1000), .C_TIM_FREQ(100), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .en_i(en),
    .mode_i(mode), .load_i(load), .period_i(period),
    .tick_o(tick), .busy_o(busy), .count_o(count)
`ifdef PROG_TIMER_TICK_CNT_EN
    , .tick_cnt_o(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_start(input logic m);
    start = 1; mode = m; step; start = 0;
  endtask

  task do_stop;
    stop = 1; step; stop = 0;
  endtask

  initial begin
    step; step;
    rst = 0; #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);

    en = 1;
    do_start(0);
    n_tick = 0;
    for (int c = 1; c <= 35; c++) begin
      chk("per_busy", int'(busy), 1);
      chk("per_count", int'(count), (c - 1) % 10);
      chk("per_tick", int'(tick), (c % 10 == 0) ? 1 : 0);
      n_tick += int'(tick);
      step;
    end
    chk("per_ntick", n_tick, 3);
    chk("stop_at5_cnt", int'(count), 5);
    do_stop;
    chk("stop_busy", int'(busy), 0);
    chk("stop_count", int'(count), 0);

    do_start(1);
    for (int c = 1; c <= 10; c++) begin
      chk("os_count", int'(count), c - 1);
      chk("os_tick", int'(tick), (c == 10) ? 1 : 0);
      step;
    end
    chk("os_busy_fall", int'(busy), 0);
    chk("os_count_clr", int'(count), 0);
    n_tick = 0;
    for (int c = 0; c < 15; c++) begin
      n_tick += int'(tick) + int'(busy);
      step;
    end
    chk("os_quiet", n_tick, 0);

    do_start(0);
    for (int c = 0; c < 4; c++) step;
    en = 0; #1;
    for (int c = 0; c < 5; c++) begin
      chk("pause_count", int'(count), 4);
      chk("pause_tick", int'(tick), 0);
      step;
    end
    en = 1; #1;
    for (int k = 0; k <= 5; k++) begin
      chk("resume_count", int'(count), 4 + k);
      chk("resume_tick", int'(tick), (k == 5) ? 1 : 0);
      step;
    end
    chk("resume_wrap", int'(count), 0);
    do_stop;

    do_start(0);
    for (int c = 0; c < 7; c++) step;
    chk("ld_pre_count", int'(count), 7);
    load = 1; period = 3; step; load = 0;
    chk("ld_clear", int'(count), 0);
    for (int c = 1; c <= 9; c++) begin
      chk("ld3_count", int'(count), (c - 1) % 3);
      chk("ld3_tick", int'(tick), (c % 3 == 0) ? 1 : 0);
      step;
    end
    load = 1; period = 0; step; load = 0; #1;
    chk("ld0_count", int'(count), 1);
    step;
    chk("ld0_tick", int'(tick), 1);
    chk("ld0_count2", int'(count), 2);
    step;
    chk("ld0_wrap", int'(count), 0);
    do_stop;

    start = 1; stop = 1; step; start = 0; stop = 0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_count", int'(count), 0);

    load = 1; period = 20; step; load = 0;
    do_start(0);
    for (int c = 0; c < 6; c++) step;
    chk("rst6_count", int'(count), 6);
    rst = 1; step; rst = 0; #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_tick", int'(tick), 0);
    do_start(0);
    for (int c = 1; c <= 9; c++) begin
      chk("restore_tick", int'(tick), 0);
      step;
    end
    stop = 1; #1;
    chk("restore_cnt9", int'(count), 9);
    chk("stop_tick_kept", int'(tick), 1);
    step; stop = 0;
    chk("stop_tc_busy", int'(busy), 0);

    load = 1; period = 1; step; load = 0;
    do_start(0);
    for (int c = 0; c < 3; c++) begin
      chk("p1_tick", int'(tick), 1);
      chk("p1_count", int'(count), 0);
      step;
    end
`ifdef PROG_TIMER_TICK_CNT_EN
    chk("tc_small", int'(tick_cnt), 3);
    for (int c = 0; c < 70000; c++) step;
    chk("tc_sat", int'(tick_cnt), 65535);
    do_stop;
    do_start(0);
    chk("tc_clr", int'(tick_cnt), 0);
`endif
    do_stop;
    chk("end_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
